// File: rtl/noc_pkg.sv
// Shared NoC definitions: default payload width, port one-hot codes,
// output-port control state encoding and a one-hot test helper.
package noc_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int NUM_PORTS  = 4;

   // Port one-hot codes, ordered {n,w,e,l} with N in the MSB.
   localparam logic [NUM_PORTS-1:0] PORT_N = 4'b1000;
   localparam logic [NUM_PORTS-1:0] PORT_W = 4'b0100;
   localparam logic [NUM_PORTS-1:0] PORT_E = 4'b0010;
   localparam logic [NUM_PORTS-1:0] PORT_L = 4'b0001;

   typedef enum logic [0:0] {
      OC_IDLE = 1'b0,
      OC_XFER = 1'b1
   } oc_state_e;

   // True when exactly one bit of the grant vector is set.
   function automatic logic is_onehot4(input logic [NUM_PORTS-1:0] v);
      return (v != '0) && ((v & (v - 4'd1)) == '0);
   endfunction

endpackage

// File: rtl/s_output_port_ctrl_if.sv
// Arbiter / input-port / south-link signal bundle of the south output port.
// slave = the controller, master = the surrounding router (or a bench).
interface s_output_port_ctrl_if
   import noc_pkg::*;
   #(parameter int DATA_W = DATA_W_DEF);

   logic                            rrp_s_priority_to_cs_i;
   logic [NUM_PORTS-1:0]            rrp_s_grant_i;
   logic [NUM_PORTS*DATA_W-1:0]     in_flit_i;
   logic [NUM_PORTS-1:0]            in_valid_i;
   logic [NUM_PORTS-1:0]            in_tail_i;
   logic [NUM_PORTS-1:0]            in_ready_o;
   logic [DATA_W-1:0]               s_flit_o;
   logic                            s_valid_o;
   logic                            s_tail_o;
   logic                            s_ready_i;
   logic                            rr_register_change_order_o;
   logic                            s_busy_o;
   logic [NUM_PORTS-1:0]            s_owner_o;
   logic                            s_err_o;

   modport slave (
      input  rrp_s_priority_to_cs_i, rrp_s_grant_i, in_flit_i, in_valid_i,
             in_tail_i, s_ready_i,
      output in_ready_o, s_flit_o, s_valid_o, s_tail_o,
             rr_register_change_order_o, s_busy_o, s_owner_o, s_err_o
   );

   modport master (
      output rrp_s_priority_to_cs_i, rrp_s_grant_i, in_flit_i, in_valid_i,
             in_tail_i, s_ready_i,
      input  in_ready_o, s_flit_o, s_valid_o, s_tail_o,
             rr_register_change_order_o, s_busy_o, s_owner_o, s_err_o
   );

endinterface

// File: rtl/noc_pipe_reg.sv
// One-entry output register with valid/ready. Accepts a new entry whenever
// it is empty or its current entry is being drained in the same cycle.
module noc_pipe_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_tail,
   output logic              load_o,
   input  logic              out_ready,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data,
   output logic              out_tail
);

   logic ld;

   assign load_o = !out_vld || out_ready;
   assign ld     = in_vld && load_o;

   // Replace on load (also when draining in the same cycle), else clear on drain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_tail <= 1'b0;
      end else if (ld) begin
         out_vld  <= 1'b1;
         out_data <= in_data;
         out_tail <= in_tail;
      end else if (out_ready) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/s_output_port_ctrl.sv
// South output-port controller: locks the port to one granted input for a
// whole packet, steers that input's flits into the output register, and
// releases on tail (or on length overrun) with a one-cycle change-order pulse.
module s_output_port_ctrl
   import noc_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_FLITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   s_output_port_ctrl_if.slave  bus
);

   localparam int CNT_W = $clog2(MAX_FLITS) + 1;

   oc_state_e                          state;
   logic [NUM_PORTS-1:0]               owner;
   logic [CNT_W-1:0]                   flit_cnt;
   logic [CNT_W-1:0]                   cnt_nxt;
   logic                               busy;
   logic                               err;
   logic                               chg;

   logic [NUM_PORTS-1:0][DATA_W-1:0]   lane_flit;
   logic [NUM_PORTS-1:0][DATA_W-1:0]   lane_sel;
   logic [DATA_W-1:0]                  own_flit;
   logic                               own_vld;
   logic                               own_tail;
   logic                               xfer_req;
   logic                               load;
   logic                               xfer;
   logic                               at_max;

   assign lane_flit = bus.in_flit_i;

   // Per-lane gating of the flit bus by the latched owner.
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
      assign lane_sel[g] = owner[g] ? lane_flit[g] : '0;
   end

   // AND-OR owner mux; owner is one-hot or zero so at most one lane contributes.
   always_comb begin
      own_flit = '0;
      for (int i = 0; i < NUM_PORTS; i++) own_flit = own_flit | lane_sel[i];
   end

   assign own_vld  = |(bus.in_valid_i & owner);
   assign own_tail = |(bus.in_tail_i & owner);
   assign xfer_req = (state == OC_XFER) && own_vld;
   assign xfer     = xfer_req && load;
   assign cnt_nxt  = flit_cnt + 1'b1;
   assign at_max   = (cnt_nxt == CNT_W'(MAX_FLITS));

   assign bus.in_ready_o = ((state == OC_XFER) && load) ? owner : '0;

   noc_pipe_reg #(.DATA_W(DATA_W)) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .in_vld    (xfer_req),
      .in_data   (own_flit),
      .in_tail   (own_tail),
      .load_o    (load),
      .out_ready (bus.s_ready_i),
      .out_vld   (bus.s_valid_o),
      .out_data  (bus.s_flit_o),
      .out_tail  (bus.s_tail_o)
   );

   // Ownership FSM: grant capture in IDLE, flit counting and release in XFER.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= OC_IDLE;
         owner    <= '0;
         flit_cnt <= '0;
         busy     <= 1'b0;
         err      <= 1'b0;
         chg      <= 1'b0;
      end else begin
         chg <= 1'b0;
         case (state)
            OC_IDLE: begin
               if (bus.rrp_s_priority_to_cs_i) begin
                  if (is_onehot4(bus.rrp_s_grant_i)) begin
                     state    <= OC_XFER;
                     owner    <= bus.rrp_s_grant_i;
                     flit_cnt <= '0;
                     busy     <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            OC_XFER: begin
               if (xfer) begin
                  flit_cnt <= cnt_nxt;
                  // Overrun without tail is treated as a tail but flagged.
                  if (own_tail || at_max) begin
                     state <= OC_IDLE;
                     owner <= '0;
                     busy  <= 1'b0;
                     chg   <= 1'b1;
                     if (!own_tail) err <= 1'b1;
                  end
               end
            end
            default: state <= OC_IDLE;
         endcase
      end
   end

   assign bus.rr_register_change_order_o = chg;
   assign bus.s_busy_o                   = busy;
   assign bus.s_owner_o                  = owner;
   assign bus.s_err_o                    = err;

endmodule

// File: tb/tb_s_output_port_ctrl.sv
// Directed bench for s_output_port_ctrl with a flit scoreboard.
module tb_s_output_port_ctrl;
   import noc_pkg::*;

   localparam int DW = 32;
   localparam int MF = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   s_output_port_ctrl_if #(.DATA_W(DW)) bus ();

   s_output_port_ctrl #(.DATA_W(DW), .MAX_FLITS(MF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_pulse  = 0;
   bit          lat_chk  = 1'b0;
   logic [DW:0] sb[$];
   int          push_cyc[$];
   int          pop_cyc[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Output monitor: counts change-order pulse cycles and scores every drained flit.
   initial forever begin
      logic [DW:0] exp;
      int          pc;
      @(negedge clk);
      if (bus.rr_register_change_order_o) n_pulse++;
      if (bus.s_valid_o && bus.s_ready_i) begin
         n_checks++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_flit observed=%0h expected=none", bus.s_flit_o);
         end
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            pc  = push_cyc.pop_front();
            check("sb_flit", {bus.s_tail_o, bus.s_flit_o}, exp);
            if (lat_chk) check("out_latency", cyc - pc, 0);
            pop_cyc.push_back(cyc);
         end
      end
   end

   // Grant one port for one cycle, then offer n flits on that port.
   task automatic send_pkt(input logic [3:0] g, input int n, input logic [7:0] base,
                           input bit last_tail, input bit chk_lat);
      int          lane;
      int          w;
      logic [DW-1:0] f;
      logic        t;
      lane = 0;
      for (int k = 0; k < NUM_PORTS; k++) if (g[k]) lane = k;
      bus.rrp_s_priority_to_cs_i = 1'b1;
      bus.rrp_s_grant_i          = g;
      @(posedge clk); #1;
      bus.rrp_s_priority_to_cs_i = 1'b0;
      bus.rrp_s_grant_i          = '0;
      for (int i = 0; i < n; i++) begin
         f = DW'(base) + DW'(i);
         t = last_tail && (i == n - 1);
         bus.in_flit_i                 = '0;
         bus.in_flit_i[lane*DW +: DW]  = f;
         bus.in_valid_i                = g;
         bus.in_tail_i                 = t ? g : 4'b0;
         w = 0;
         @(negedge clk);
         while (!bus.in_ready_o[lane] && w < 20) begin
            w++;
            @(negedge clk);
         end
         if (w >= 20) begin
            n_checks++;
            n_fail++;
            $error("FAIL ready_timeout observed=0 expected=1 lane=%0d", lane);
            break;
         end
         check("ready_vec", bus.in_ready_o, g);
         if (chk_lat) check("ready_lat", w, 0);
         @(posedge clk); #1;
         sb.push_back({t, f});
         push_cyc.push_back(cyc);
      end
      bus.in_valid_i = '0;
      bus.in_tail_i  = '0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int p0;
      bus.rrp_s_priority_to_cs_i = 1'b0;
      bus.rrp_s_grant_i          = '0;
      bus.in_flit_i              = '0;
      bus.in_valid_i             = '0;
      bus.in_tail_i              = '0;
      bus.s_ready_i              = 1'b1;

      // Reset state
      idle_cycles(2);
      check("reset_state",
            {bus.s_valid_o, bus.s_tail_o, bus.s_flit_o, bus.in_ready_o,
             bus.rr_register_change_order_o, bus.s_busy_o, bus.s_owner_o, bus.s_err_o}, 0);
      reset = 1'b1;
      idle_cycles(2);

      // Single packet on W, full rate
      p0 = n_pulse;
      pop_cyc.delete();
      lat_chk = 1'b1;
      send_pkt(PORT_W, 3, 8'hA1, 1'b1, 1'b1);
      check("release_busy", {bus.s_busy_o, bus.s_owner_o}, 0);
      @(negedge clk);
      check("chg_pulse_hi", bus.rr_register_change_order_o, 1);
      @(negedge clk);
      check("chg_pulse_lo", bus.rr_register_change_order_o, 0);
      lat_chk = 1'b0;
      check("single_pulses", n_pulse - p0, 1);
      check("single_cnt", pop_cyc.size(), 3);
      check("single_gap1", pop_cyc[1] - pop_cyc[0], 1);
      check("single_gap2", pop_cyc[2] - pop_cyc[1], 1);
      check("err_clean1", bus.s_err_o, 0);

      // Backpressure mid-packet
      idle_cycles(1);
      p0 = n_pulse;
      fork
         send_pkt(PORT_W, 4, 8'hB1, 1'b1, 1'b0);
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.s_ready_i = 1'b0;
            for (int s = 0; s < 4; s++) begin
               @(negedge clk);
               check("bp_hold", {bus.s_valid_o, bus.s_tail_o, bus.s_flit_o}, {2'b10, 32'hB2});
               check("bp_ready", bus.in_ready_o, 0);
            end
            check("bp_owner", {bus.s_busy_o, bus.s_owner_o}, {1'b1, PORT_W});
            @(posedge clk); #1;
            bus.s_ready_i = 1'b1;
         end
      join
      idle_cycles(3);
      check("bp_drained", sb.size(), 0);
      check("bp_pulses", n_pulse - p0, 1);

      // Back-to-back owners L then E
      p0 = n_pulse;
      pop_cyc.delete();
      send_pkt(PORT_L, 2, 8'hC1, 1'b1, 1'b1);
      send_pkt(PORT_E, 2, 8'hD1, 1'b1, 1'b1);
      idle_cycles(3);
      check("b2b_cnt", pop_cyc.size(), 4);
      check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 1);
      check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 2);
      check("b2b_gap3", pop_cyc[3] - pop_cyc[2], 1);
      check("b2b_pulses", n_pulse - p0, 2);
      check("err_clean2", bus.s_err_o, 0);

      // Bad (multi-hot) grant
      p0 = n_pulse;
      bus.in_valid_i             = 4'b1111;
      bus.rrp_s_priority_to_cs_i = 1'b1;
      bus.rrp_s_grant_i          = 4'b0110;
      @(posedge clk); #1;
      bus.rrp_s_priority_to_cs_i = 1'b0;
      bus.rrp_s_grant_i          = '0;
      @(negedge clk);
      check("bad_grant_err", bus.s_err_o, 1);
      check("bad_grant_idle", {bus.s_busy_o, bus.s_owner_o, bus.in_ready_o}, 0);
      bus.in_valid_i = '0;
      idle_cycles(2);
      check("bad_grant_pulses", n_pulse - p0, 0);

      // Reset mid-packet after flit 2
      send_pkt(PORT_L, 2, 8'hE1, 1'b0, 1'b0);
      p0 = n_pulse;
      reset = 1'b0;
      #1;
      check("async_reset",
            {bus.s_valid_o, bus.s_tail_o, bus.s_flit_o, bus.in_ready_o,
             bus.rr_register_change_order_o, bus.s_busy_o, bus.s_owner_o, bus.s_err_o}, 0);
      sb.delete();
      push_cyc.delete();
      idle_cycles(2);
      reset = 1'b1;
      idle_cycles(1);
      check("reset_no_pulse", n_pulse - p0, 0);
      send_pkt(PORT_L, 2, 8'hF1, 1'b1, 1'b1);
      idle_cycles(3);
      check("post_reset_drain", sb.size(), 0);
      check("post_reset_pulse", n_pulse - p0, 1);
      check("post_reset_err", bus.s_err_o, 0);

      // Overrun: MF flits with no tail force release
      p0 = n_pulse;
      send_pkt(PORT_N, MF, 8'h51, 1'b0, 1'b1);
      check("overrun_err", bus.s_err_o, 1);
      check("overrun_release", {bus.s_busy_o, bus.s_owner_o}, 0);
      bus.in_flit_i              = '0;
      bus.in_flit_i[3*DW +: DW]  = 32'h55;
      bus.in_valid_i             = PORT_N;
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         check("overrun_drop", bus.in_ready_o, 0);
      end
      bus.in_valid_i = '0;
      idle_cycles(3);
      check("overrun_pulses", n_pulse - p0, 1);
      check("overrun_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
